// File: rtl/systolic_array_tile_pkg.sv
// Shared types and helpers for the NPU systolic matrix-multiply tile.
//   sa_state_e : tile control state
//   prod_w()   : width of an operand product (2 * operand width)
//   idx_w()    : width of an index into n items (never below 1)
//   SA_*_DEF   : default array size / widths
package npu_sa_pkg;

  localparam int SA_N_DEF      = 8;
  localparam int SA_DATA_W_DEF = 8;
  localparam int SA_ACC_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_e;

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_tile_if.sv
// Streaming bus of the systolic tile.
//   Operand channel: ab_valid / ab_ready, a (column k of A), b (row k of B)
//   Result channel : c_valid / c_ready, c (one row of C), c_row, c_last
//   master : operand producer / result consumer
//   slave  : the tile
interface systolic_array_tile_if #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int RW     = (N > 1) ? $clog2(N) : 1
);
  logic                  ab_valid;
  logic                  ab_ready;
  logic [N*DATA_W-1:0]   a;
  logic [N*DATA_W-1:0]   b;
  logic                  c_valid;
  logic                  c_ready;
  logic [N*ACC_W-1:0]    c;
  logic [RW-1:0]         c_row;
  logic                  c_last;

  modport master (
    output ab_valid, a, b, c_ready,
    input  ab_ready, c_valid, c, c_row, c_last
  );

  modport slave (
    input  ab_valid, a, b, c_ready,
    output ab_ready, c_valid, c, c_row, c_last
  );
endinterface

// File: rtl/systolic_array_tile_pe_mac.sv
// Single processing element of the output-stationary array.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : global step enable (operands forwarded, product accumulated)
//   i_clr        : clear accumulator and forwarding registers
//   i_signed     : 1 = operands are two's complement
//   i_a, i_b     : operands arriving from the left / from above
//   o_a, o_b     : registered operands forwarded right / down
//   o_acc        : accumulator (wraps modulo 2^ACC_W)
module pe_mac
  import npu_sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [ACC_W-1:0]  o_acc
);
  localparam int PW = prod_w(DATA_W);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PW-1:0]     a_x, b_x, prod;
  logic [ACC_W-1:0]  prod_ext;

  always_comb begin
    // Extending both operands to PW bits first makes one multiplier serve both
    // modes: the low PW bits of the product are exact in either case.
    a_x      = {{DATA_W{i_signed & i_a[DATA_W-1]}}, i_a};
    b_x      = {{DATA_W{i_signed & i_b[DATA_W-1]}}, i_b};
    prod     = a_x * b_x;
    prod_ext = i_signed ? ACC_W'(signed'(prod)) : ACC_W'(prod);

    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (i_clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (i_en) begin
      a_d   = i_a;
      b_d   = i_b;
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign o_a   = a_q;
  assign o_b   = b_q;
  assign o_acc = acc_q;
endmodule

// File: rtl/systolic_array_tile.sv
// Output-stationary NxN integer matrix-multiply tile: C = A(NxK) x B(KxN).
//   i_clk, i_arst : clock, synchronous active-high reset
//   i_start       : start pulse (IDLE only); latches i_k, i_accumulate, i_signed
//   i_k           : reduction length (0 drains current accumulators)
//   i_accumulate  : 1 = continue summing into existing accumulators
//   i_signed      : 1 = two's-complement operands
//   io            : operand stream in, row-serial result stream out
//   o_busy        : tile not idle
//   o_done        : one-cycle pulse after the last result row is accepted
module systolic_array_tile
  import npu_sa_pkg::*;
#(
  parameter int N      = SA_N_DEF,
  parameter int DATA_W = SA_DATA_W_DEF,
  parameter int ACC_W  = SA_ACC_W_DEF,
  parameter int K_MAX  = 1024,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_start,
  input  logic [KW-1:0]          i_k,
  input  logic                   i_accumulate,
  input  logic                   i_signed,
  systolic_array_tile_if.slave   io,
  output logic                   o_busy,
  output logic                   o_done
);
  localparam int RW         = idx_w(N);
  localparam int FW         = idx_w(2 * N - 1);
  localparam int FLUSH_LAST = 2 * N - 3;

  if (ACC_W < prod_w(DATA_W)) begin : g_acc_w_check
    $error("systolic_array_tile: ACC_W must be at least 2*DATA_W");
  end

  sa_state_e      state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [KW-1:0]  beat_q, beat_d;
  logic [FW-1:0]  flush_q, flush_d;
  logic [RW-1:0]  row_q, row_d;
  logic           signed_q, signed_d;
  logic           done_q, done_d;
  logic           en, clr, feed;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    beat_d   = beat_q;
    flush_d  = flush_q;
    row_d    = row_q;
    signed_d = signed_q;
    done_d   = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    feed     = (state_q == LOAD);

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          k_d      = i_k;
          signed_d = i_signed;
          clr      = !i_accumulate;
          beat_d   = '0;
          flush_d  = '0;
          row_d    = '0;
          state_d  = (i_k != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        if (io.ab_valid) begin
          en     = 1'b1;
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == k_q) begin
            flush_d = '0;
            state_d = (N > 1) ? FLUSH : DRAIN;
          end
        end
      end
      FLUSH: begin
        en      = 1'b1;
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(FLUSH_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (io.c_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      beat_q   <= '0;
      flush_q  <= '0;
      row_q    <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      beat_q   <= beat_d;
      flush_q  <= flush_d;
      row_q    <= row_d;
      signed_q <= signed_d;
      done_q   <= done_d;
    end
  end

  // Input skew: row/column i is delayed by i enabled stages so that callers can
  // present unskewed vectors. Zeros are fed outside LOAD to flush the wavefront.
  logic [DATA_W-1:0] a_row [N];
  logic [DATA_W-1:0] b_col [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_in, b_in;
    assign a_in = feed ? io.a[i*DATA_W +: DATA_W] : '0;
    assign b_in = feed ? io.b[i*DATA_W +: DATA_W] : '0;

    if (i == 0) begin : g_pass
      assign a_row[i] = a_in;
      assign b_col[i] = b_in;
    end else begin : g_dly
      logic [DATA_W-1:0] a_q [i];
      logic [DATA_W-1:0] a_d [i];
      logic [DATA_W-1:0] b_q [i];
      logic [DATA_W-1:0] b_d [i];

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en) begin
          a_d[0] = a_in;
          b_d[0] = b_in;
          for (int unsigned s = 1; s < i; s++) begin
            a_d[s] = a_q[s-1];
            b_d[s] = b_q[s-1];
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_arst) begin
          for (int unsigned s = 0; s < i; s++) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
          end
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_row[i] = a_q[i-1];
      assign b_col[i] = b_q[i-1];
    end
  end

  logic [DATA_W-1:0] pe_a_out [N][N];
  logic [DATA_W-1:0] pe_b_out [N][N];
  logic [ACC_W-1:0]  acc      [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_in, b_in;

      if (j == 0) begin : g_a_edge
        assign a_in = a_row[i];
      end else begin : g_a_int
        assign a_in = pe_a_out[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = b_col[j];
      end else begin : g_b_int
        assign b_in = pe_b_out[i-1][j];
      end

      pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .i_clk    (i_clk),
        .i_rst    (i_arst),
        .i_en     (en),
        .i_clr    (clr),
        .i_signed (signed_q),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_a      (pe_a_out[i][j]),
        .o_b      (pe_b_out[i][j]),
        .o_acc    (acc[i][j])
      );
    end
  end

  always_comb begin
    io.c = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (row_q == RW'(r)) begin
        for (int unsigned j = 0; j < N; j++) begin
          io.c[j*ACC_W +: ACC_W] = acc[r][j];
        end
      end
    end
  end

  assign io.ab_ready = (state_q == LOAD);
  assign io.c_valid  = (state_q == DRAIN);
  assign io.c_row    = row_q;
  assign io.c_last   = (state_q == DRAIN) && (row_q == RW'(N - 1));
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
endmodule

// File: tb/tb_systolic_array_tile.sv
module tb_systolic_array_tile;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int KM  = 1024;
  localparam int KW  = $clog2(KM + 1);
  localparam int KM1 = 16;
  localparam int KW1 = $clog2(KM1 + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, accm = 1'b0, sgn = 1'b0;
  logic [KW-1:0] k_in = '0;
  logic          busy, done;

  logic           start1 = 1'b0, accm1 = 1'b0, sgn1 = 1'b0;
  logic [KW1-1:0] k_in1 = '0;
  logic           busy1, done1;

  always #5 clk = ~clk;

  systolic_array_tile_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) ifc ();
  systolic_array_tile_if #(.N(1), .DATA_W(8), .ACC_W(16))  ifc1 ();

  systolic_array_tile #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) u_dut (
    .i_clk(clk), .i_arst(rst), .i_start(start), .i_k(k_in),
    .i_accumulate(accm), .i_signed(sgn), .io(ifc),
    .o_busy(busy), .o_done(done)
  );

  systolic_array_tile #(.N(1), .DATA_W(8), .ACC_W(16), .K_MAX(KM1)) u_ovf (
    .i_clk(clk), .i_arst(rst), .i_start(start1), .i_k(k_in1),
    .i_accumulate(accm1), .i_signed(sgn1), .io(ifc1),
    .o_busy(busy1), .o_done(done1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Operands: opa[k][i] = A[i][k], opb[k][j] = B[k][j]
  logic [DW-1:0] opa [32][N];
  logic [DW-1:0] opb [32][N];
  logic [AW-1:0] exp_c [N][N];
  logic [AW-1:0] got_c [N][N];
  logic [AW-1:0] full_c [N][N];

  function automatic longint ext8(input logic [7:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reference: plain matrix product over the beats of this run, on top of the
  // previous result when accumulating, wrapped to the accumulator width.
  task automatic model_run(input int k, input bit acc, input bit s);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint sum;
        sum = acc ? longint'(exp_c[i][j]) : 64'sd0;
        for (int t = 0; t < k; t++) sum += ext8(opa[t][i], s) * ext8(opb[t][j], s);
        exp_c[i][j] = sum[AW-1:0];
      end
  endtask

  function automatic logic [N*DW-1:0] pack_a(input int t);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = opa[t][i];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int t);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = opb[t][j];
    return v;
  endfunction

  // Compare process: every drained row against the model, o_done pulse timing,
  // row index / last flag, and stability while the consumer stalls.
  int            exp_row = 0;
  bit            done_pend = 0;
  bit            hold = 0;
  logic [N*AW-1:0] hold_c;
  logic [1:0]    hold_row;
  int            rdy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_row   = 0;
      done_pend = 0;
      hold      = 0;
    end else begin
      chk("o_done", 128'(done), 128'(done_pend));
      done_pend = 0;
      if (ifc.ab_ready) rdy_cnt++;
      if (hold) begin
        chk("hold_c", ifc.c, hold_c);
        chk("hold_row", 128'(ifc.c_row), 128'(hold_row));
      end
      hold = 0;
      if (ifc.c_valid) begin
        chk("c_row", 128'(ifc.c_row), 128'(exp_row));
        chk("c_last", 128'(ifc.c_last), 128'(exp_row == N - 1));
        for (int j = 0; j < N; j++)
          chk("c_elem", 128'(ifc.c[j*AW +: AW]), 128'(exp_c[exp_row][j]));
        if (ifc.c_ready) begin
          for (int j = 0; j < N; j++) got_c[exp_row][j] = ifc.c[j*AW +: AW];
          if (exp_row == N - 1) begin
            exp_row   = 0;
            done_pend = 1;
          end else begin
            exp_row++;
          end
        end else begin
          hold     = 1;
          hold_c   = ifc.c;
          hold_row = ifc.c_row;
        end
      end
    end
  end

  task automatic run(input int k, input bit acc, input bit s, input bit gaps, input bit rnd_rdy);
    int beat, cyc;
    bit took, seen;
    model_run(k, acc, s);
    rdy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; k_in = KW'(k); accm = acc; sgn = s;
    @(posedge clk); #1;
    start = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < k && cyc < 2000) begin
      ifc.ab_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifc.a = pack_a(beat);
      ifc.b = pack_b(beat);
      @(negedge clk);
      took = ifc.ab_valid && ifc.ab_ready;
      @(posedge clk); #1;
      if (took) beat++;
      cyc++;
    end
    ifc.ab_valid = 1'b0;
    if (beat < k) chk("load_timeout", 128'(beat), 128'(k));
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 500) begin
      ifc.c_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("drain_done_seen", 128'(seen), 128'(1));
    chk("busy_at_done", 128'(busy), 128'(0));
    @(posedge clk); #1;
    ifc.c_ready = 1'b0;
  endtask

  task automatic fill_identity();
    for (int t = 0; t < N; t++)
      for (int i = 0; i < N; i++) begin
        opa[t][i] = (i == t) ? 8'd1 : 8'd0;
        opb[t][i] = 8'(t * 4 + i + 1);
      end
  endtask

  initial begin
    int cyc, beat;
    bit seen;
    ifc.ab_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.c_ready = 1'b0;
    ifc1.ab_valid = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.c_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ab_ready", 128'(ifc.ab_ready), 128'(0));
    chk("rst_c_valid", 128'(ifc.c_valid), 128'(0));
    chk("rst_c", ifc.c, 128'(0));
    chk("rst_c_row", 128'(ifc.c_row), 128'(0));
    chk("rst_c_last", 128'(ifc.c_last), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity A: rows of C equal rows of B
    fill_identity();
    run(4, 0, 0, 0, 0);
    chk("ident_ready_cycles", 128'(rdy_cnt), 128'(4));
    chk("ident_c00", 128'(got_c[0][0]), 128'(1));
    chk("ident_c12", 128'(got_c[1][2]), 128'(7));
    chk("ident_c30", 128'(got_c[3][0]), 128'(13));

    // -1 * 2 over three beats, signed and unsigned
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < N; i++) begin
        opa[t][i] = 8'hFF;
        opb[t][i] = 8'd2;
      end
    run(3, 0, 1, 0, 0);
    chk("signed_c21", 128'(got_c[2][1]), 128'(32'hFFFF_FFFA));
    run(3, 0, 0, 0, 0);
    chk("unsigned_c03", 128'(got_c[0][3]), 128'(1530));

    // Random operands with producer gaps and consumer stalls
    for (int t = 0; t < 17; t++)
      for (int i = 0; i < N; i++) begin
        opa[t][i] = 8'($urandom);
        opb[t][i] = 8'($urandom);
      end
    run(17, 0, 1, 1, 1);

    // Split reduction equals the single long reduction
    for (int t = 0; t < 16; t++)
      for (int i = 0; i < N; i++) begin
        opa[t][i] = 8'($urandom);
        opb[t][i] = 8'($urandom);
      end
    run(16, 0, 0, 0, 0);
    full_c = got_c;
    run(8, 0, 0, 1, 0);
    for (int t = 0; t < 8; t++) begin
      opa[t] = opa[t+8];
      opb[t] = opb[t+8];
    end
    run(8, 1, 0, 0, 1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("split_vs_full", 128'(got_c[i][j]), 128'(full_c[i][j]));
    run(0, 1, 0, 0, 0);
    chk("k0_keep_c11", 128'(got_c[1][1]), 128'(full_c[1][1]));
    chk("k0_keep_c32", 128'(got_c[3][2]), 128'(full_c[3][2]));

    // Reset in the middle of LOAD, then accumulate on top: must see no residue
    fill_identity();
    @(posedge clk); #1;
    start = 1'b1; k_in = KW'(4); accm = 1'b0; sgn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ifc.ab_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      ifc.a = pack_a(t);
      ifc.b = pack_b(t);
      @(posedge clk); #1;
    end
    ifc.ab_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ab_ready", 128'(ifc.ab_ready), 128'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = '0;
    run(4, 1, 0, 0, 0);
    chk("postrst_c22", 128'(got_c[2][2]), 128'(11));

    // Single-PE tile, 16-bit accumulator wrap: 5*127*127 = 80645 -> 15109
    @(posedge clk); #1;
    start1 = 1'b1; k_in1 = KW1'(5); accm1 = 1'b0; sgn1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    ifc1.ab_valid = 1'b1; ifc1.a = 8'd127; ifc1.b = 8'd127;
    beat = 0;
    cyc  = 0;
    while (beat < 5 && cyc < 100) begin
      @(negedge clk);
      if (ifc1.ab_ready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    ifc1.ab_valid = 1'b0;
    ifc1.c_ready  = 1'b1;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (ifc1.c_valid) seen = 1;
      else cyc++;
    end
    chk("ovf_valid_seen", 128'(seen), 128'(1));
    chk("ovf_c", 128'(ifc1.c), 128'(15109));
    chk("ovf_last", 128'(ifc1.c_last), 128'(1));
    @(negedge clk);
    chk("ovf_done", 128'(done1), 128'(1));
    chk("ovf_busy", 128'(busy1), 128'(0));
    ifc1.c_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_array_tile.md
Name: systolic_array_tile

Overview:
- Output-stationary NxN int matrix-multiply tile; computes C = A(NxK) x B(KxN) with K streamed at run time.
- Successor to the fixed 8-bit/32-bit array. Adds:
  - internal input skewing, so callers send unskewed vectors;
  - parametrised operand and accumulator widths, and a signed/unsigned mode;
  - valid/ready streaming with stall, and a K-split accumulate mode;
  - row-serial result drain.
- Sits between the operand buffers and the output/activation stage of the NPU datapath.

Parameters:
- N, 8, array dimension (rows = cols), >= 1
- DATA_W, 8, operand width
- ACC_W, 32, accumulator width; must be >= 2*DATA_W (elaboration assertion)
- K_MAX, 1024, maximum reduction length per start
- KW, $clog2(K_MAX+1), derived, width of i_k

Ports:
- i_clk  in  1  clock
- i_arst  in  1  reset, synchronous, active-high (name retained for codebase consistency)
- i_start  in  1  start pulse; sampled only in IDLE
- i_k  in  KW  reduction length, latched at start
- i_accumulate  in  1  latched at start; 1 = keep prior accumulators, 0 = clear
- i_signed  in  1  latched at start; 1 = two's-complement operands
- i_ab_valid  in  1  operand beat valid
- o_ab_ready  out  1  high in LOAD
- i_a  in  N*DATA_W  column k of A; element i feeds row i
- i_b  in  N*DATA_W  row k of B; element j feeds column j
- o_busy  out  1  state != IDLE
- o_c_valid  out  1  result row valid (DRAIN)
- i_c_ready  in  1  result row accepted
- o_c  out  N*ACC_W  C[o_c_row][0..N-1]
- o_c_row  out  $clog2(N) (min 1)  row index being drained
- o_c_last  out  1  o_c_valid && o_c_row == N-1
- o_done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Reset (sync, priority over everything):
  - state IDLE; all accumulators, skew registers and PE pipes zero;
  - outputs 0, except o_c, which shows accumulator row 0 (all zero after reset).
- FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
  - IDLE: on i_start, latch i_k/i_accumulate/i_signed; if !i_accumulate, clear all accumulators that edge.
    - Next state: LOAD if i_k > 0, else DRAIN.
    - i_start outside IDLE is ignored.
- LOAD: beat accepted when i_ab_valid && o_ab_ready; beat counter increments per accepted beat.
  - Global enable = accepted beat. With no beat, all skew regs, PE regs and accumulators hold (stall, no bubble injected).
  - After the K-th accepted beat -> FLUSH; o_ab_ready is low from the next cycle.
- Skew: row i input passes i enabled registers, column j passes j.
  - PE[i][j] sees (a_k, b_k) on enabled step k+i+j and does acc += ext(a)*ext(b).
  - Each PE forwards a right and b down via enabled registers.
- FLUSH: enable forced high, zeros injected at skew inputs, for exactly 2N-2 cycles.
  - N = 1 skips FLUSH (LOAD -> DRAIN).
- Arithmetic:
  - Product 2*DATA_W bits, sign- or zero-extended per latched mode to ACC_W.
  - Accumulate wraps modulo 2^ACC_W; no saturation and no overflow flag.
- DRAIN:
  - o_c_valid = 1; o_c = acc row o_c_row, starting at 0. o_c and o_c_row stable while !i_c_ready.
  - On i_c_ready, row increments. The acceptance of row N-1 -> IDLE, with o_done = 1 in that first IDLE cycle.
  - Accumulators are not cleared by drain, so i_accumulate = 1 on the next start continues summing.
- Reset mid-operation: any state aborts to IDLE in one cycle; a partial stream is discarded and accumulators are zeroed.

Decomposition:
- Package npu_sa_pkg holds:
  - state enum sa_state_e {IDLE, LOAD, FLUSH, DRAIN};
  - function for extended-product width;
  - default N/DATA_W/ACC_W constants.
- Sub-module pe_mac #(DATA_W, ACC_W): i_en, i_clr, i_signed, i_a/i_b, o_a/o_b registered, o_acc.
- Skew delay lines are generated inline in the tile.

Test Plan:
- N=4, A=I, B[k][j]=k*4+j+1, K=4, valid always high, ready always high -> rows equal B; o_done 1 cycle after row 3 accepted; o_ab_ready high exactly 4 cycles.
- Signed: all A=-1 (0xFF), all B=2, K=3, i_signed=1 -> every C = -6 (0xFFFFFFFA). Same data with i_signed=0 -> every C = 3*255*2 = 1530.
- Random A/B, K=17, i_ab_valid toggled with random gaps, i_c_ready random -> C matches reference model; o_c held stable during ready-low cycles.
- Accumulate split: K=8 with clear, then K=8 with i_accumulate=1 on the second half -> equals the single K=16 result. i_k=0 with accumulate -> drains the previous C unchanged.
- Overflow: DATA_W=8, ACC_W=16, signed, A=B=127, K=5 -> 80645 mod 65536 = 15109.
- i_arst asserted mid-LOAD after 3 beats -> next cycle IDLE, o_busy=0. A new K=4 identity run then gives correct C with no residue.
